mem_responder: RTL and testbench

- Memory-side responder for the cache request protocol: services icache (iREN/iaddr → iwait/iload) and dcache (dREN/dWEN/daddr/dstore → dwait/dload) requests.
- Fronts a single-port RAM with variable latency, reported through ramstate.
- Registered FSM: grants one requester at a time, holds the RAM request until ACCESS, then releases the requester's wait for exactly one cycle.
- Data side has priority over instruction side, matching the icache yielding to the dcache.

---
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: arbitrates icache/dcache requests onto a single-port RAM.
// The data side wins over the instruction side. One access is in flight at a time.
// The owner's wait drops for exactly one cycle when its access completes.
module mem_responder #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, DACC, IACC, DONE, ABORT} state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [7:0] TMO        = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        wr_q, wr_d;
  logic        own_d_q, own_d_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        owner_req;
  logic        hit;
  logic [7:0]  cnt_inc;
  logic        active;
  logic        unused_addr_bits;

  // Requests are word addressed; the byte offset bits are never used.
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  assign owner_req = own_d_q ? (dREN | dWEN) : iREN;
  // cnt_q counts the request-state cycles already finished; the cycle where the
  // count would reach TIMEOUT is the last one allowed before forcing an error.
  assign hit       = (cnt_q >= (TMO - 8'd1));
  assign cnt_inc   = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;

  // State and latched request registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      iload_q <= '0;
      dload_q <= '0;
      wr_q    <= 1'b0;
      own_d_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      wr_q    <= wr_d;
      own_d_q <= own_d_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant, wait for RAM completion/error/timeout, handle aborts.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    iload_d = iload_q;
    dload_d = dload_q;
    wr_d    = wr_q;
    own_d_d = own_d_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dREN | dWEN) begin
          addr_d  = daddr[31:2];
          data_d  = dstore;
          wr_d    = dWEN;
          own_d_d = 1'b1;
          state_d = DACC;
        end else if (iREN) begin
          addr_d  = iaddr[31:2];
          wr_d    = 1'b0;
          own_d_d = 1'b0;
          state_d = IACC;
        end
      end
      DACC, IACC: begin
        cnt_d = cnt_inc;
        if (ramstate == RAM_ACCESS) begin
          if (!wr_q) begin
            if (own_d_q) dload_d = ramload;
            else         iload_d = ramload;
          end
          state_d = DONE;
        end else if ((ramstate == RAM_ERROR) || hit) begin
          if (own_d_q) dload_d = ERRWORD;
          else         iload_d = ERRWORD;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!owner_req) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        cnt_d = cnt_inc;
        if ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR) || hit) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from state and latched registers only.
  assign active   = (state_q == DACC) || (state_q == IACC) || (state_q == ABORT);
  assign ramREN   = active & ~wr_q;
  assign ramWEN   = active & wr_q;
  assign ramaddr  = {addr_q, 2'b00};
  assign ramstore = data_q;
  assign iwait    = ~((state_q == DONE) && !own_d_q);
  assign dwait    = ~((state_q == DONE) && own_d_q);
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_mem_responder;

  localparam int TO = 4;
  localparam logic [31:0] EW = 32'hBAD1BAD1;
  localparam int M_ACC = 0;
  localparam int M_ERR = 1;
  localparam int M_STK = 2;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int total = 0;
  int bad = 0;

  mem_responder #(.TIMEOUT(TO), .ERRWORD(EW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM environment: word memory with a default pattern for unwritten words.
  logic [31:0] mem [logic [31:0]];
  int ram_mode = M_ACC;
  int ram_lat  = 0;
  int ram_n    = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return {w[15:0], ~w[15:0]};
  endfunction

  // Variable-latency RAM: BUSY for ram_lat enabled cycles, then ACCESS/ERROR.
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      ram_n = ram_n + 1;
      if (ram_mode == M_STK)   ramstate = 2'd1;
      else if (ram_n > ram_lat) ramstate = (ram_mode == M_ERR) ? 2'd3 : 2'd2;
      else                      ramstate = 2'd1;
      if (ramREN && ramstate == 2'd2) ramload = mem_rd(ramaddr);
      else                            ramload = $urandom;
      if (ramWEN && ramstate == 2'd2) mem[ramaddr] = ramstore;
    end else begin
      ram_n    = 0;
      ramstate = 2'd0;
      ramload  = $urandom;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference: outcome of one access from the RAM behaviour and the timeout rule.
  function automatic void model(input bit wr, input int mode, input int lat,
                                input logic [31:0] word, input logic [31:0] prev,
                                output int cyc, output logic [31:0] ld, output bit e);
    if (mode != M_STK && lat + 1 <= TO) begin
      cyc = lat + 2;
      e   = (mode == M_ERR);
      ld  = e ? EW : (wr ? prev : word);
    end else begin
      cyc = TO + 1;
      e   = 1'b1;
      ld  = EW;
    end
  endfunction

  // Issue one request from IDLE, wait (bounded) for the owner's wait pulse.
  task automatic do_txn(input bit dside, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int mode, input int lat,
                        output int cyc, output logic [31:0] ld, output bit e,
                        output bit side_ok, output bit bus_ok);
    bit done, seen;
    ram_mode = mode;
    ram_lat  = lat;
    if (dside) begin
      dREN = !wr; dWEN = wr; daddr = a; dstore = d;
    end else begin
      iREN = 1'b1; iaddr = a;
    end
    cyc = 0; ld = '0; e = 1'b0; side_ok = 1'b1; bus_ok = 1'b1;
    done = 1'b0; seen = 1'b0;
    while (!done && cyc < 300) begin
      @(posedge CLK); #1;
      cyc++;
      if (!(dside ? dwait : iwait)) begin
        done = 1'b1;
        ld   = dside ? dload : iload;
        e    = err;
        if (!(dside ? iwait : dwait)) side_ok = 1'b0;
        if (ramREN || ramWEN) bus_ok = 1'b0;
      end else begin
        if (!(dside ? iwait : dwait) || err) side_ok = 1'b0;
        if (ramREN || ramWEN) begin
          seen = 1'b1;
          if (ramaddr !== {a[31:2], 2'b00}) bus_ok = 1'b0;
          if (ramWEN !== wr || ramREN !== !wr) bus_ok = 1'b0;
          if (wr && ramstore !== d) bus_ok = 1'b0;
        end
      end
    end
    if (!seen) bus_ok = 1'b0;
    if (!done) cyc = -1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    @(posedge CLK); #1;
  endtask

  typedef struct {
    bit          dside;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          mode;
    int          lat;
    bit          pre_en;
    logic [31:0] pre;
    int          exp_cyc;
    logic [31:0] exp_load;
    bit          exp_err;
  } vec_t;

  vec_t tbl[9];
  logic [31:0] m_iload, m_dload;

  initial begin
    int cyc, ecyc, dcyc, icyc, rcnt;
    logic [31:0] ld, eld, word, ild;
    bit e, ee, sok, bok, werr, wlow, sawwen;
    bit dside, wr;
    logic [31:0] a, d;
    int mode, lat, r;

    tbl[0] = '{0, 0, 32'h104, 32'h0, M_ACC, 3, 1, 32'hDEADBEEF, 5, 32'hDEADBEEF, 0};
    tbl[1] = '{1, 0, 32'h203, 32'h0, M_ACC, 0, 1, 32'h11112222, 2, 32'h11112222, 0};
    tbl[2] = '{1, 1, 32'h300, 32'hCAFEF00D, M_ACC, 1, 0, 32'h0, 3, 32'h11112222, 0};
    tbl[3] = '{1, 0, 32'h180, 32'h0, M_STK, 0, 0, 32'h0, 5, EW, 1};
    tbl[4] = '{0, 0, 32'h188, 32'h0, M_ERR, 2, 0, 32'h0, 4, EW, 1};
    tbl[5] = '{0, 0, 32'h18C, 32'h0, M_ACC, 4, 1, 32'h55AA55AA, 5, EW, 1};
    tbl[6] = '{1, 0, 32'h302, 32'h0, M_ACC, 2, 0, 32'h0, 4, 32'hCAFEF00D, 0};
    tbl[7] = '{1, 1, 32'h310, 32'h0F0F0F0F, M_ERR, 0, 0, 32'h0, 2, EW, 1};
    tbl[8] = '{1, 0, 32'h310, 32'h0, M_ACC, 1, 0, 32'h0, 3, 32'h0310FCEF, 0};

    iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_ram_en", {30'd0, ramREN, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;
    m_iload = '0; m_dload = '0;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].pre_en) mem[{tbl[i].addr[31:2], 2'b00}] = tbl[i].pre;
      do_txn(tbl[i].dside, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].mode,
             tbl[i].lat, cyc, ld, e, sok, bok);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
      chk($sformatf("vec%0d_load", i), ld, tbl[i].exp_load);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_other_side", i), 32'(sok), 32'd1);
      chk($sformatf("vec%0d_ram_bus", i), 32'(bok), 32'd1);
      if (tbl[i].dside) m_dload = tbl[i].exp_load;
      else              m_iload = tbl[i].exp_load;
    end

    // Simultaneous iREN and dWEN: write goes first, fetch after one IDLE cycle.
    ram_mode = M_ACC; ram_lat = 0;
    iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h200; dstore = 32'h1234;
    dcyc = -1; icyc = -1; sawwen = 0; werr = 0; ild = '0;
    for (int c = 1; c <= 20 && icyc < 0; c++) begin
      @(posedge CLK); #1;
      if (ramWEN && ramstore == 32'h1234 && ramaddr == 32'h200 && !ramREN) sawwen = 1;
      if (ramREN && dcyc < 0) werr = 1;
      if (err) werr = 1;
      if (!dwait) begin dcyc = c; dWEN = 0; if (!iwait) werr = 1; end
      if (!iwait) begin icyc = c; ild = iload; iREN = 0; end
    end
    @(posedge CLK); #1;
    chk("both_dwait_cycle", 32'(dcyc), 32'd2);
    chk("both_iwait_cycle", 32'(icyc), 32'd5);
    chk("both_write_bus", 32'(sawwen), 32'd1);
    chk("both_order_err", 32'(werr), 32'd0);
    chk("both_iload", ild, 32'h1234);
    chk("both_dload_kept", dload, m_dload);
    m_iload = 32'h1234;

    // Instruction side drops its request one cycle into the access.
    ram_mode = M_ACC; ram_lat = 3;
    iREN = 1; iaddr = 32'h40;
    @(posedge CLK); #1;
    iREN = 0;
    rcnt = 0; wlow = 0; werr = 0;
    for (int c = 0; c < 10; c++) begin
      if (ramREN) rcnt++;
      if (!iwait || !dwait) wlow = 1;
      if (err) werr = 1;
      @(posedge CLK); #1;
    end
    chk("abort_ren_cycles", 32'(rcnt), 32'd4);
    chk("abort_no_wait", 32'(wlow), 32'd0);
    chk("abort_no_err", 32'(werr), 32'd0);
    chk("abort_iload_kept", iload, m_iload);
    word = mem_rd(32'h44);
    do_txn(1, 0, 32'h44, 32'h0, M_ACC, 0, cyc, ld, e, sok, bok);
    chk("after_abort_cycles", 32'(cyc), 32'd2);
    chk("after_abort_dload", ld, word);
    chk("after_abort_bus", 32'(bok), 32'd1);
    m_dload = word;

    // Asynchronous reset in the middle of an instruction access.
    ram_mode = M_STK; ram_lat = 0;
    iREN = 1; iaddr = 32'h500;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("midrst_pre_ren", 32'(ramREN), 32'd1);
    #3 nRST = 1'b0;
    #1;
    chk("midrst_async_ren", 32'(ramREN), 32'd0);
    chk("midrst_async_iwait", 32'(iwait), 32'd1);
    @(posedge CLK); #1;
    chk("midrst_ren", 32'(ramREN), 32'd0);
    chk("midrst_iwait", 32'(iwait), 32'd1);
    chk("midrst_iload", iload, 32'h0);
    chk("midrst_dload", dload, 32'h0);
    chk("midrst_ramaddr", ramaddr, 32'h0);
    iREN = 0;
    #2 nRST = 1'b1;
    @(posedge CLK); #1;
    m_iload = '0; m_dload = '0;

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      dside = 1'($urandom_range(0, 1));
      wr    = dside && ($urandom_range(0, 2) == 0);
      a     = $urandom & 32'h0000_003F;
      d     = $urandom;
      r     = $urandom_range(0, 9);
      mode  = (r < 7) ? M_ACC : (r < 9) ? M_ERR : M_STK;
      lat   = $urandom_range(0, 5);
      word  = mem_rd(a);
      model(wr, mode, lat, word, dside ? m_dload : m_iload, ecyc, eld, ee);
      do_txn(dside, wr, a, d, mode, lat, cyc, ld, e, sok, bok);
      chk($sformatf("rnd%0d_cycles", n), 32'(cyc), 32'(ecyc));
      chk($sformatf("rnd%0d_load", n), ld, eld);
      chk($sformatf("rnd%0d_err", n), 32'(e), 32'(ee));
      chk($sformatf("rnd%0d_other_side", n), 32'(sok), 32'd1);
      chk($sformatf("rnd%0d_ram_bus", n), 32'(bok), 32'd1);
      chk($sformatf("rnd%0d_other_load", n), dside ? iload : dload,
          dside ? m_iload : m_dload);
      if (dside) m_dload = eld;
      else       m_iload = eld;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
